// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared encodings, constants and decode helpers for the RV32M multiply/divide unit
package muldiv_pkg;
  localparam int XLEN = 32;
  localparam logic [4:0] STEP_COUNT = 5'd31;
  typedef enum logic [2:0] {
    F_MUL, F_MULH, F_MULHSU, F_MULHU, F_DIV, F_DIVU, F_REM, F_REMU
  } funct3_e;
  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;
  function automatic logic is_div(input logic [2:0] f);
    return f[2];
  endfunction
  function automatic logic op_a_signed(input logic [2:0] f);
    return f == F_MULH || f == F_MULHSU || f == F_DIV || f == F_REM;
  endfunction
  function automatic logic op_b_signed(input logic [2:0] f);
    return f == F_MULH || f == F_DIV || f == F_REM;
  endfunction
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one shift-add or restoring-subtract step per cycle
import muldiv_pkg::*;
module muldiv_unit (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNCT3,
  input  logic [XLEN-1:0] OPERAND_A,
  input  logic [XLEN-1:0] OPERAND_B,
  input  logic [4:0]      RD_IN,
  input  logic            FLUSH,
  output logic            BUSY,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      RD_OUT
);
  state_e state, state_n;
  logic [4:0] cnt, rd;
  logic [2:0] f3;
  logic [63:0] acc, acc_n, prod;
  logic [31:0] opnd, a_mag, b_mag, quo, rem, res;
  logic [32:0] add_a, add_b, sum;
  logic neg, a_neg, sa, sb, dz, dv, accept;
  assign sa = op_a_signed(FUNCT3) & OPERAND_A[31];
  assign sb = op_b_signed(FUNCT3) & OPERAND_B[31];
  assign a_mag = sa ? -OPERAND_A : OPERAND_A;
  assign b_mag = sb ? -OPERAND_B : OPERAND_B;
  assign dz = is_div(FUNCT3) && OPERAND_B == '0;
  assign accept = state == S_IDLE && START && !FLUSH;
  assign dv = is_div(f3);
  // one 33-bit adder serves both: add for multiply, subtract (invert + carry-in) for divide
  assign add_a = dv ? acc[63:31] : {1'b0, acc[63:32]};
  assign add_b = dv ? ~{1'b0, opnd} : {1'b0, opnd};
  assign sum = add_a + add_b + 33'(dv);
  always_comb begin
    acc_n = dv ? (sum[32] ? {acc[62:0], 1'b0} : {sum[31:0], acc[30:0], 1'b1})
               : (acc[0] ? {sum, acc[31:1]} : {1'b0, acc[63:1]});
    prod = neg ? -acc : acc;
    quo = neg ? -acc[31:0] : acc[31:0];
    rem = a_neg ? -acc[63:32] : acc[63:32];
    res = dv ? (f3[1] ? rem : quo) : (f3 == F_MUL ? prod[31:0] : prod[63:32]);
  end
  always_comb begin
    state_n = state;
    if (FLUSH)
      state_n = S_IDLE;
    else if (state == S_IDLE)
      state_n = START ? (dz ? S_FIXUP : S_CALC) : S_IDLE;
    else if (state == S_CALC)
      state_n = cnt == '0 ? S_FIXUP : S_CALC;
    else
      state_n = state == S_FIXUP ? S_DONE : S_IDLE;
  end
  always_ff @(posedge CLK)
    if (RESET) state <= S_IDLE;
    else state <= state_n;
  // divide-by-zero preloads quotient all-ones and remainder = dividend, with quotient negation suppressed
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt <= '0;
      rd <= '0;
      f3 <= '0;
      acc <= '0;
      opnd <= '0;
      neg <= 1'b0;
      a_neg <= 1'b0;
      RESULT <= '0;
      RD_OUT <= '0;
    end else begin
      if (accept) begin
        cnt <= STEP_COUNT;
        rd <= RD_IN;
        f3 <= FUNCT3;
        opnd <= b_mag;
        acc <= dz ? {a_mag, 32'hFFFF_FFFF} : {32'b0, a_mag};
        neg <= (sa ^ sb) & ~dz;
        a_neg <= sa;
      end
      if (state == S_CALC) begin
        acc <= acc_n;
        cnt <= cnt - 5'd1;
      end
      if (state == S_FIXUP && !FLUSH) begin
        RESULT <= res;
        RD_OUT <= rd;
      end
    end
  end
  assign BUSY = state != S_IDLE;
  assign DONE = state == S_DONE;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against an arithmetic reference model
module tb_muldiv_unit;
  logic CLK = 1'b0;
  logic RESET, START, FLUSH, BUSY, DONE;
  logic [2:0] FUNCT3;
  logic [31:0] OPERAND_A, OPERAND_B, RESULT;
  logic [4:0] RD_IN, RD_OUT;
  int errors = 0;
  int checks = 0;
  always #5 CLK = ~CLK;
  muldiv_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNCT3(FUNCT3),
    .OPERAND_A(OPERAND_A), .OPERAND_B(OPERAND_B), .RD_IN(RD_IN), .FLUSH(FLUSH),
    .BUSY(BUSY), .DONE(DONE), .RESULT(RESULT), .RD_OUT(RD_OUT)
  );
  typedef struct {
    logic [2:0] f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int lat;
  } vec_t;
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] xa, xb, p;
    int sa, sb;
    xa = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (f == 3'd1) ? {{32{b[31]}}, b} : {32'b0, b};
    p = xa * xb;
    sa = a;
    sb = b;
    if (f == 3'd0) return p[31:0];
    if (f < 3'd4) return p[63:32];
    if (b == 32'd0) return (f == 3'd4 || f == 3'd5) ? 32'hFFFF_FFFF : a;
    if (f == 3'd4) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
      return 32'(sa / sb);
    end
    if (f == 3'd6) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
      return 32'(sa % sb);
    end
    if (f == 3'd5) return a / b;
    return a % b;
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(1, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output int lat, output int busy);
    FUNCT3 = f;
    OPERAND_A = a;
    OPERAND_B = b;
    RD_IN = rd;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    lat = 1;
    busy = 0;
    while (lat < 100) begin
      if (BUSY) busy++;
      if (DONE) break;
      @(negedge CLK);
      lat++;
    end
  endtask
  task automatic test_reset();
    RESET = 1'b1;
    START = 1'b0;
    FLUSH = 1'b0;
    FUNCT3 = '0;
    OPERAND_A = '0;
    OPERAND_B = '0;
    RD_IN = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    checks++;
    if ({BUSY, DONE, RESULT, RD_OUT} !== 39'd0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b result=%h rd=%0d want all zero", BUSY, DONE, RESULT, RD_OUT);
    end
  endtask
  task automatic test_directed();
    vec_t v[14];
    int lat, busy;
    v = '{
      '{3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34},
      '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34},
      '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34},
      '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34},
      '{3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34},
      '{3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34},
      '{3'd5, 32'd100, 32'd7, 32'd14, 34},
      '{3'd7, 32'd100, 32'd7, 32'd2, 34},
      '{3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 2},
      '{3'd6, 32'd5, 32'd0, 32'd5, 2},
      '{3'd4, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFFF, 2},
      '{3'd6, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 2},
      '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34},
      '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34}
    };
    for (int i = 0; i < 14; i++) begin
      run_op(v[i].f, v[i].a, v[i].b, 5'(i + 3), lat, busy);
      checks += 4;
      if (RESULT !== v[i].exp) begin
        errors++;
        $display("FAIL directed[%0d] result got=%h want=%h", i, RESULT, v[i].exp);
      end
      if (RD_OUT !== 5'(i + 3)) begin
        errors++;
        $display("FAIL directed[%0d] rd got=%0d want=%0d", i, RD_OUT, i + 3);
      end
      if (lat !== v[i].lat || busy !== v[i].lat) begin
        errors++;
        $display("FAIL directed[%0d] timing done_at=%0d busy_cycles=%0d want=%0d", i, lat, busy, v[i].lat);
      end
      @(negedge CLK);
      if (DONE !== 1'b0 || BUSY !== 1'b0) begin
        errors++;
        $display("FAIL directed[%0d] after_done done=%b busy=%b want 0 0", i, DONE, BUSY);
      end
    end
  endtask
  task automatic test_back_to_back();
    logic [2:0] f;
    logic [31:0] a, b, exp;
    logic [4:0] rd;
    int lat, busy;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      rd = 5'($urandom_range(0, 31));
      exp = model(f, a, b);
      run_op(f, a, b, rd, lat, busy);
      checks += 3;
      if (RESULT !== exp || RD_OUT !== rd) begin
        errors++;
        $display("FAIL random[%0d] f=%0d a=%h b=%h result=%h rd=%0d want %h rd=%0d", i, f, a, b, RESULT, RD_OUT, exp, rd);
      end
      if (lat !== ((f[2] && b == 0) ? 2 : 34)) begin
        errors++;
        $display("FAIL random[%0d] latency got=%0d f=%0d b=%h", i, lat, f, b);
      end
      @(negedge CLK);
      if (BUSY !== 1'b0) begin
        errors++;
        $display("FAIL random[%0d] idle_gap busy=%b want 0", i, BUSY);
      end
    end
  endtask
  task automatic test_flush();
    int lat, busy, dones;
    run_op(3'd0, 32'd3, 32'd5, 5'd11, lat, busy);
    @(negedge CLK);
    FUNCT3 = 3'd0;
    OPERAND_A = 32'd1000;
    OPERAND_B = 32'd1000;
    RD_IN = 5'd22;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (9) @(negedge CLK);
    FLUSH = 1'b1;
    @(negedge CLK);
    FLUSH = 1'b0;
    checks++;
    if (BUSY !== 1'b0) begin
      errors++;
      $display("FAIL flush busy=%b want 0", BUSY);
    end
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checks += 2;
    if (dones !== 0) begin
      errors++;
      $display("FAIL flush done_pulses got=%0d want 0", dones);
    end
    if (RESULT !== 32'd15 || RD_OUT !== 5'd11) begin
      errors++;
      $display("FAIL flush held result=%h rd=%0d want 0000000f rd=11", RESULT, RD_OUT);
    end
  endtask
  task automatic test_start_held();
    int lat, dones;
    FUNCT3 = 3'd5;
    OPERAND_A = 32'd100;
    OPERAND_B = 32'd7;
    RD_IN = 5'd9;
    START = 1'b1;
    @(negedge CLK);
    lat = 1;
    while (!DONE && lat < 100) begin
      @(negedge CLK);
      lat++;
    end
    START = 1'b0;
    checks += 2;
    if (lat !== 34) begin
      errors++;
      $display("FAIL start_held latency got=%0d want 34", lat);
    end
    if (RESULT !== 32'd14) begin
      errors++;
      $display("FAIL start_held result got=%h want 0000000e", RESULT);
    end
    dones = 0;
    repeat (40) begin
      @(negedge CLK);
      if (DONE) dones++;
    end
    checks++;
    if (dones !== 0 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL start_held extra_done=%0d busy=%b want 0 0", dones, BUSY);
    end
  endtask
  task automatic test_start_flush();
    int busy_seen;
    FUNCT3 = 3'd0;
    OPERAND_A = 32'd2;
    OPERAND_B = 32'd2;
    RD_IN = 5'd1;
    START = 1'b1;
    FLUSH = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    FLUSH = 1'b0;
    busy_seen = 0;
    repeat (40) begin
      if (BUSY || DONE) busy_seen++;
      @(negedge CLK);
    end
    checks++;
    if (busy_seen !== 0 || RESULT !== 32'd14) begin
      errors++;
      $display("FAIL start_flush busy_cycles=%0d result=%h want 0 0000000e", busy_seen, RESULT);
    end
  endtask
  task automatic test_reset_mid();
    int lat, busy;
    FUNCT3 = 3'd0;
    OPERAND_A = 32'd7;
    OPERAND_B = 32'd9;
    RD_IN = 5'd3;
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    checks++;
    if ({BUSY, DONE, RESULT, RD_OUT} !== 39'd0) begin
      errors++;
      $display("FAIL reset_mid busy=%b done=%b result=%h rd=%0d want all zero", BUSY, DONE, RESULT, RD_OUT);
    end
    run_op(3'd5, 32'd9, 32'd3, 5'd4, lat, busy);
    checks++;
    if (RESULT !== 32'd3 || RD_OUT !== 5'd4 || lat !== 34) begin
      errors++;
      $display("FAIL reset_mid divu result=%h rd=%0d lat=%0d want 00000003 4 34", RESULT, RD_OUT, lat);
    end
    @(negedge CLK);
  endtask
  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_flush();
    test_start_held();
    test_start_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
